// File: rtl/uart_top.sv
// ---------------------------------------------------------------------------
// uart_top
//
// Memory-mapped 8N1 UART with an 8-bit register interface.
//
// Software first writes a byte to the TX data register. It then sets SEND
// (control bit 0), and the transmitter shifts the byte out on tx. Frames
// received on rx are captured in the RX data register and flagged through
// RX_VALID (control bit 1).
//
// Ports
//   clk_i            system clock
//   reset_i          asynchronous, active-high reset
//   data_in[7:0]     bus write data
//   reg_sel_i        0 = control register, 1 = data register
//   wr_i             level-sensitive write strobe (writes every edge while high)
//   rx               serial input, idle high, asynchronous to clk_i
//   data_out[7:0]    combinational read: RX data (reg_sel_i=1) or control
//   tx               serial output, idle high
//   instruccion_test current control register value (debug)
//   ins_uart[3:0]    current TX FSM state code (debug)
// ---------------------------------------------------------------------------
module uart_top #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] data_in,
    input  logic       reg_sel_i,
    input  logic       wr_i,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       tx,
    output logic [7:0] instruccion_test,
    output logic [3:0] ins_uart
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [3:0] {
        TX_IDLE  = 4'd0,
        TX_START = 4'd1,
        TX_DATA  = 4'd2,
        TX_STOP  = 4'd3,
        TX_DONE  = 4'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_t;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic       send_reg, send_next;
    logic       rx_valid_reg, rx_valid_next;
    logic [7:0] tx_data_reg, tx_data_next;
    logic [7:0] rx_data_reg, rx_data_next;

    logic       ctrl_wr;
    logic       data_wr;
    logic       rx_load;

    tx_state_t  tx_state_reg, tx_state_next;

    assign ctrl_wr = wr_i & ~reg_sel_i;
    assign data_wr = wr_i & reg_sel_i;

    always_comb begin
        send_next     = send_reg;
        rx_valid_next = rx_valid_reg;
        tx_data_next  = tx_data_reg;
        // DONE clears SEND, but a software write in the same cycle wins.
        if (tx_state_reg == TX_DONE) begin
            send_next = 1'b0;
        end
        if (ctrl_wr) begin
            send_next     = data_in[0];
            rx_valid_next = data_in[1];
        end
        // A hardware receive beats a software clear of RX_VALID.
        if (rx_load) begin
            rx_valid_next = 1'b1;
        end
        if (data_wr) begin
            tx_data_next = data_in;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            send_reg     <= 1'b0;
            rx_valid_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
            rx_data_reg  <= 8'h00;
        end else begin
            send_reg     <= send_next;
            rx_valid_reg <= rx_valid_next;
            tx_data_reg  <= tx_data_next;
            rx_data_reg  <= rx_data_next;
        end
    end

    assign instruccion_test = {6'b000000, rx_valid_reg, send_reg};
    assign ins_uart         = tx_state_reg;
    assign data_out         = reg_sel_i ? rx_data_reg : instruccion_test;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0]       tx_bit_reg, tx_bit_next;
    logic [7:0]       tx_shift_reg, tx_shift_next;
    logic             tx_reg, tx_next;

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        case (tx_state_reg)
            TX_IDLE: begin
                // The byte is copied here, so bus writes during a frame
                // cannot disturb the bits already in flight.
                if (send_reg) begin
                    tx_shift_next = tx_data_reg;
                    tx_cnt_next   = '0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = 3'd0;
                    tx_state_next = TX_DATA;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = TX_STOP;
                    end else begin
                        tx_bit_next = tx_bit_reg + 1'b1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_state_next = TX_DONE;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_DONE: begin
                tx_state_next = TX_IDLE;
            end
            default: begin
                tx_state_next = TX_IDLE;
            end
        endcase

        // tx is registered from the next state, so the line changes on the
        // same edge that the state changes and is glitch-free.
        case (tx_state_next)
            TX_START: tx_next = 1'b0;
            TX_DATA:  tx_next = tx_shift_next[0];
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= 3'd0;
            tx_shift_reg <= 8'h00;
            tx_reg       <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_reg       <= tx_next;
        end
    end

    assign tx = tx_reg;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic             rx_meta_reg, rx_sync_reg, rx_prev_reg;
    rx_state_t        rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]       rx_bit_reg, rx_bit_next;
    logic [7:0]       rx_shift_reg, rx_shift_next;

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_data_next  = rx_data_reg;
        rx_load       = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_prev_reg && !rx_sync_reg) begin
                    rx_cnt_next   = '0;
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                // Confirm the start bit half a bit in. This re-centres the
                // timer so that all later samples land at mid-bit.
                if (rx_cnt_reg == HALF_LAST) begin
                    rx_cnt_next = '0;
                    if (!rx_sync_reg) begin
                        rx_bit_next   = 3'd0;
                        rx_state_next = RX_DATA;
                    end else begin
                        rx_state_next = RX_IDLE;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    if (rx_bit_reg == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        rx_bit_next = rx_bit_reg + 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next = '0;
                    if (rx_sync_reg) begin
                        rx_data_next  = rx_shift_reg;
                        rx_load       = 1'b1;
                        rx_state_next = RX_IDLE;
                    end else begin
                        // Framing error: drop the byte and wait for the line
                        // to go idle, so a held-low line cannot retrigger.
                        rx_state_next = RX_WAIT;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_WAIT: begin
                if (rx_sync_reg) begin
                    rx_state_next = RX_IDLE;
                end
            end
            default: begin
                rx_state_next = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= 3'd0;
            rx_shift_reg <= 8'h00;
        end else begin
            rx_meta_reg  <= rx;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end

endmodule

// File: tb/tb_uart_top.sv
// ---------------------------------------------------------------------------
// tb_uart_top
//
// Self-checking bench for uart_top, using a short bit time.
//
// The expected serial waveform comes from the 8N1 frame rule: a 0 start bit,
// then eight data bits LSB first, then a 1 stop bit. The expected register
// values come from a small model of what software has written and what the
// receiver has accepted.
// ---------------------------------------------------------------------------
module tb_uart_top;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       reg_sel_i = 1'b0;
    logic       wr_i = 1'b0;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx_w;
    logic [7:0] data_out;
    logic       tx_w;
    logic [7:0] instruccion_test;
    logic [3:0] ins_uart;

    int total = 0;
    int bad = 0;
    logic [7:0] rx_model = 8'h00;   // last byte the receiver should hold

    assign rx_w = loop_en ? tx_w : rx_drv;

    uart_top #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .data_in          (data_in),
        .reg_sel_i        (reg_sel_i),
        .wr_i             (wr_i),
        .rx               (rx_w),
        .data_out         (data_out),
        .tx               (tx_w),
        .instruccion_test (instruccion_test),
        .ins_uart         (ins_uart)
    );

    always #10 clk = ~clk;

    // Reference: the value of frame bit idx (0 = start ... 9 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    function automatic logic [3:0] frame_state(input int idx);
        if (idx == 0) return 4'd1;
        if (idx == 9) return 4'd3;
        return 4'd2;
    endfunction

    task automatic write_reg(input logic sel, input logic [7:0] v);
        @(negedge clk);
        wr_i = 1'b1; reg_sel_i = sel; data_in = v;
        @(negedge clk);
        wr_i = 1'b0; reg_sel_i = 1'b0;
    endtask

    task automatic read_reg(input logic sel, output logic [7:0] v);
        @(negedge clk);
        reg_sel_i = sel;
        #1 v = data_out;
        reg_sel_i = 1'b0;
    endtask

    // Call this at the negedge that follows the edge where SEND was written.
    // It checks every cycle of the frame and then the DONE cycle. It can
    // also perform one register write during the frame, at cycle inj_j.
    task automatic check_frame(input logic [7:0] b, input int inj_j,
                               input logic inj_sel, input logic [7:0] inj_v,
                               input string name);
        int idx;
        int errs;
        errs = 0;
        for (int j = 1; j <= 10 * CPB; j++) begin
            @(negedge clk);
            idx = (j - 1) / CPB;
            total++;
            if (tx_w !== frame_bit(b, idx) || ins_uart !== frame_state(idx)) begin
                bad++;
                errs++;
                if (errs <= 4)
                    $display("FAIL %s cycle %0d: tx=%b ins_uart=%0d, required tx=%b ins_uart=%0d",
                             name, j, tx_w, ins_uart, frame_bit(b, idx), frame_state(idx));
            end
            if (inj_j > 0 && j == inj_j) begin
                wr_i = 1'b1; reg_sel_i = inj_sel; data_in = inj_v;
            end else if (inj_j > 0 && j == inj_j + 1) begin
                wr_i = 1'b0; reg_sel_i = 1'b0;
            end
        end
        @(negedge clk);
        total++;
        if (ins_uart !== 4'd4) begin
            bad++;
            $display("FAIL %s done_state: ins_uart=%0d required 4", name, ins_uart);
        end
    endtask

    task automatic expect_idle_clear(input string name);
        logic [7:0] v;
        @(negedge clk);
        total++;
        if (ins_uart !== 4'd0 || instruccion_test !== 8'h00 || tx_w !== 1'b1) begin
            bad++;
            $display("FAIL %s after_done: ins_uart=%0d instr=%h tx=%b required 0/00/1",
                     name, ins_uart, instruccion_test, tx_w);
        end
        read_reg(1'b0, v);
        total++;
        if (v !== 8'h00) begin
            bad++;
            $display("FAIL %s ctrl_read: got %h required 00", name, v);
        end
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
        for (int i = 0; i < 10; i++) begin
            rx_drv = (i == 9) ? stop_bit : frame_bit(b, i);
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic expect_rx(input logic [7:0] ctrl_exp, input string name);
        logic [7:0] c;
        logic [7:0] d;
        read_reg(1'b0, c);
        read_reg(1'b1, d);
        total++;
        if (c !== ctrl_exp || d !== rx_model) begin
            bad++;
            $display("FAIL %s: ctrl=%h data=%h required ctrl=%h data=%h",
                     name, c, d, ctrl_exp, rx_model);
        end
        $display("rx %s: ctrl=%h data=%h", name, c, d);
    endtask

    // ---------------------------------------------------------------
    task automatic test_reset();
        logic [7:0] c;
        logic [7:0] d;
        #5 reset_i = 1'b1;
        #30 reset_i = 1'b0;
        read_reg(1'b0, c);
        read_reg(1'b1, d);
        total++;
        if (tx_w !== 1'b1 || ins_uart !== 4'd0 || instruccion_test !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs: tx=%b ins_uart=%0d instr=%h required 1/0/00",
                     tx_w, ins_uart, instruccion_test);
        end
        total++;
        if (c !== 8'h00 || d !== 8'h00) begin
            bad++;
            $display("FAIL reset_regs: ctrl=%h data=%h required 00/00", c, d);
        end
        $display("reset: tx=%b ins_uart=%0d ctrl=%h data=%h", tx_w, ins_uart, c, d);
    endtask

    task automatic test_transmit();
        write_reg(1'b1, 8'h55);
        write_reg(1'b0, 8'h01);
        check_frame(8'h55, 0, 1'b0, 8'h00, "transmit_55");
        expect_idle_clear("transmit_55");
        $display("tx frame 55 checked");
    endtask

    task automatic test_mid_frame_write();
        logic [7:0] b;
        b = 8'($urandom_range(0, 254));
        write_reg(1'b1, b);
        write_reg(1'b0, 8'h01);
        check_frame(b, 3 * CPB, 1'b1, 8'hFF, "midframe_data");
        expect_idle_clear("midframe_data");
        write_reg(1'b0, 8'h01);
        check_frame(8'hFF, 0, 1'b0, 8'h00, "midframe_second");
        expect_idle_clear("midframe_second");
        // Writing SEND=0 mid-frame must not abort the frame.
        b = 8'($urandom_range(0, 255));
        write_reg(1'b1, b);
        write_reg(1'b0, 8'h01);
        check_frame(b, 5 * CPB, 1'b0, 8'h00, "midframe_send0");
        expect_idle_clear("midframe_send0");
        $display("mid-frame writes checked, byte %h", b);
    endtask

    task automatic test_held_strobe();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        write_reg(1'b1, b);
        @(negedge clk);
        wr_i = 1'b1; reg_sel_i = 1'b0; data_in = 8'h01;
        @(negedge clk);
        check_frame(b, 0, 1'b0, 8'h00, "held_first");
        @(negedge clk);
        total++;
        if (ins_uart !== 4'd0 || instruccion_test !== 8'h01) begin
            bad++;
            $display("FAIL held_after_done: ins_uart=%0d instr=%h required 0/01",
                     ins_uart, instruccion_test);
        end
        wr_i = 1'b0;
        check_frame(b, 0, 1'b0, 8'h00, "held_second");
        expect_idle_clear("held_second");
        $display("held strobe: two frames of %h", b);
    endtask

    task automatic test_random_tx();
        logic [7:0] b;
        for (int n = 0; n < 3; n++) begin
            b = 8'($urandom_range(0, 255));
            write_reg(1'b1, b);
            write_reg(1'b0, 8'h01);
            check_frame(b, 0, 1'b0, 8'h00, "random_tx");
            expect_idle_clear("random_tx");
            $display("tx random frame %h checked", b);
        end
    endtask

    task automatic test_loopback();
        loop_en = 1'b1;
        write_reg(1'b1, 8'hA3);
        write_reg(1'b0, 8'h01);
        check_frame(8'hA3, 0, 1'b0, 8'h00, "loopback");
        rx_model = 8'hA3;
        expect_rx(8'h02, "loopback_A3");
        write_reg(1'b0, 8'h00);
        expect_rx(8'h00, "loopback_clear");
        loop_en = 1'b0;
    endtask

    task automatic test_framing_error();
        drive_rx_frame(8'h3C, 1'b0);
        expect_rx(8'h00, "framing_3C");
        drive_rx_frame(8'h81, 1'b1);
        rx_model = 8'h81;
        expect_rx(8'h02, "after_framing_81");
        write_reg(1'b0, 8'h00);
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        expect_rx(8'h00, "start_glitch");
    endtask

    task automatic test_random_rx();
        logic [7:0] b;
        for (int n = 0; n < 5; n++) begin
            b = 8'($urandom_range(0, 255));
            drive_rx_frame(b, 1'b1);
            rx_model = b;
            expect_rx(8'h02, "random_rx");
            write_reg(1'b0, 8'h00);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        write_reg(1'b1, 8'h00);
        write_reg(1'b0, 8'h01);
        repeat (3 * CPB) @(negedge clk);
        #3 reset_i = 1'b1;
        #1;
        total++;
        if (tx_w !== 1'b1 || ins_uart !== 4'd0 || instruccion_test !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_frame: tx=%b ins_uart=%0d instr=%h required 1/0/00",
                     tx_w, ins_uart, instruccion_test);
        end
        @(negedge clk);
        reset_i = 1'b0;
        rx_model = 8'h00;
        read_reg(1'b1, d);
        total++;
        if (d !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_frame_rxdata: got %h required 00", d);
        end
        $display("reset mid-frame: tx=%b ins_uart=%0d", tx_w, ins_uart);
    endtask

    initial begin
        test_reset();
        test_transmit();
        test_mid_frame_write();
        test_held_strobe();
        test_random_tx();
        test_loopback();
        test_framing_error();
        test_glitch();
        test_random_rx();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
